loading_bar_screen: RTL

- Animated, parametrised loading screen for the 96x64 OLED pixel pipeline.
- Sits between the pixel-coordinate generator (x, y) and the OLED driver's oled_data input.
- Draws a framed progress bar that fills over time, or on external step pulses, in NUM_SEG segments.
- Signals completion with a one-cycle done pulse, then blinks the full bar until cleared or restarted.

---
 rtl/oled_pkg.sv | 30 +++
 rtl/tick_prescaler.sv | 38 +++
 rtl/loading_bar_screen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oled_pkg
// Description : Shared constants and types for the 96x64 OLED pixel pipeline:
//               RGB565 colours, screen dimensions, loading-screen state type.
// Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

  // RGB565 colour constants
  localparam logic [15:0] c_BLACK      = 16'h0000;
  localparam logic [15:0] c_WHITE      = 16'hFFFF;
  localparam logic [15:0] c_LIGHTGREEN = 16'hAFE5;
  localparam logic [15:0] c_RED        = 16'hF800;
  localparam logic [15:0] c_GREEN      = 16'h07E0;
  localparam logic [15:0] c_BLUE       = 16'h001F;

  // Panel geometry
  localparam int c_SCREEN_W = 96;
  localparam int c_SCREEN_H = 64;

  // Loading screen controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_DONE    = 2'd2
  } loading_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running modulo-MAX counter with enable and synchronous
//               clear; wrap is high in the cycle the count sits at MAX-1
//               while enabled (the count returns to 0 on that edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int              c_CW   = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(MAX - 1);

  logic [c_CW-1:0] r_count;

  assign wrap = en && (r_count == c_LAST);

  // Count enabled cycles, wrapping at MAX-1; clear dominates enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/loading_bar_screen.sv
`default_nettype none
// ============================================================================
// Module      : loading_bar_screen
// Description : Animated framed progress bar for the 96x64 OLED. Fills in
//               NUM_SEG segments on a timer or on step pulses, pulses done
//               when full, then blinks the full bar until cleared/restarted.
// Revision    : 1.0 - initial release
// ============================================================================
module loading_bar_screen
  import oled_pkg::*;
#(
  parameter int          NUM_SEG       = 4,
  parameter int          TICKS_PER_SEG = 25_000_000,
  parameter int          BLINK_TICKS   = 12_500_000,
  parameter int          BAR_X0        = 14,
  parameter int          BAR_X1        = 85,
  parameter int          BAR_Y0        = 30,
  parameter int          BAR_Y1        = 45,
  parameter int          FRAME_W       = 3,
  parameter logic [15:0] FILL_COLOUR   = c_LIGHTGREEN,
  parameter logic [15:0] FRAME_COLOUR  = c_BLACK,
  parameter logic [15:0] BG_COLOUR     = c_WHITE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             clear,
  input  logic                             step,
  input  logic [6:0]                       x,
  input  logic [5:0]                       y,
  output logic [15:0]                      oled_data,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(NUM_SEG+1)-1:0]     seg_count
);

  localparam int            c_SW       = $clog2(NUM_SEG + 1);
  localparam int            c_W        = BAR_X1 - BAR_X0 + 1;
  localparam int            c_SEG_W    = c_W / NUM_SEG;
  localparam logic [c_SW-1:0] c_SEG_FULL = c_SW'(NUM_SEG);
  localparam int            c_OX0      = BAR_X0 - FRAME_W;
  localparam int            c_OX1      = BAR_X1 + FRAME_W;
  localparam int            c_OY0      = BAR_Y0 - FRAME_W;
  localparam int            c_OY1      = BAR_Y1 + FRAME_W;

  // Fill edge for a given segment count; a full bar reaches past BAR_X1 so
  // the last segment absorbs the division remainder.
  function automatic logic [7:0] fill_edge(input int seg);
    if (seg >= NUM_SEG) return 8'(BAR_X1 + 1);
    else                return 8'(BAR_X0 + seg * c_SEG_W);
  endfunction

  loading_state_t    r_state;
  logic [c_SW-1:0]   r_seg_count;
  logic [7:0]        r_fill_x;
  logic              r_busy;
  logic              r_done;
  logic              r_blink_phase;
  logic [15:0]       r_oled_data;

  logic              w_loading;
  logic              w_in_done;
  logic              w_seg_wrap;
  logic              w_blink_wrap;
  logic              w_advance;
  logic [c_SW-1:0]   w_seg_inc;
  logic              w_show_fill;
  logic              w_frame;
  logic              w_fill;
  int                w_px;
  int                w_py;
  logic              w_in_outer;
  logic              w_in_inner;

  assign w_loading = (r_state == ST_LOADING);
  assign w_in_done = (r_state == ST_DONE);
  assign w_advance = w_loading && (w_seg_wrap || step);
  assign w_seg_inc = r_seg_count + 1'b1;

  // Segment timer: held at zero outside LOADING and restarted by step
  tick_prescaler #(.MAX(TICKS_PER_SEG)) u_seg_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear || !w_loading || step),
    .en    (w_loading),
    .wrap  (w_seg_wrap)
  );

  // Blink timer: held at zero outside DONE so each DONE entry starts fresh
  tick_prescaler #(.MAX(BLINK_TICKS)) u_blink_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear || !w_in_done),
    .en    (w_in_done),
    .wrap  (w_blink_wrap)
  );

  // Control FSM: state, segment count, fill edge, busy and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_seg_count <= '0;
      r_fill_x    <= fill_edge(0);
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_seg_count <= '0;
      r_fill_x    <= fill_edge(0);
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOADING;
            r_busy  <= 1'b1;
          end
        end
        ST_LOADING: begin
          if (w_advance) begin
            r_seg_count <= w_seg_inc;
            r_fill_x    <= fill_edge(int'(w_seg_inc));
            if (w_seg_inc == c_SEG_FULL) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            r_state     <= ST_LOADING;
            r_busy      <= 1'b1;
            r_seg_count <= '0;
            r_fill_x    <= fill_edge(0);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_seg_count <= '0;
          r_fill_x    <= fill_edge(0);
        end
      endcase
    end
  end

  // Blink phase: parked high outside DONE, toggles on each blink-timer wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_phase <= 1'b1;
    end else if (clear || !w_in_done) begin
      r_blink_phase <= 1'b1;
    end else if (w_blink_wrap) begin
      r_blink_phase <= ~r_blink_phase;
    end
  end

  // Pixel classification against the frame and interior rectangles
  always_comb begin
    w_px        = {25'd0, x};
    w_py        = {26'd0, y};
    w_in_outer  = (w_px >= c_OX0) && (w_px <= c_OX1) &&
                  (w_py >= c_OY0) && (w_py <= c_OY1);
    w_in_inner  = (w_px >= BAR_X0) && (w_px <= BAR_X1) &&
                  (w_py >= BAR_Y0) && (w_py <= BAR_Y1);
    w_show_fill = w_in_done ? r_blink_phase : 1'b1;
    w_frame     = w_in_outer && !w_in_inner;
    w_fill      = w_in_inner && (w_px < {24'd0, r_fill_x}) && w_show_fill;
  end

  // Registered pixel colour, frame taking priority over fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_oled_data <= BG_COLOUR;
    end else if (w_frame) begin
      r_oled_data <= FRAME_COLOUR;
    end else if (w_fill) begin
      r_oled_data <= FILL_COLOUR;
    end else begin
      r_oled_data <= BG_COLOUR;
    end
  end

  assign oled_data = r_oled_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign seg_count = r_seg_count;

endmodule
`default_nettype wire
